// File: rtl/tensaurus_pkg.sv
// Shared types and helpers for the tensaurus CSF decode path.
//   tok_t       : 2-bit token type carried on the input stream
//   dec_state_t : decoder control states (run / drain / done)
//   lvl_width() : width of a header-level index for a given level count
package tensaurus_pkg;

    typedef enum logic [1:0] {
        TOK_HDR  = 2'b00,
        TOK_NNZ  = 2'b01,
        TOK_EOS  = 2'b10,
        TOK_RSVD = 2'b11
    } tok_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } dec_state_t;

    // A level index always needs at least one bit, even for a single level.
    function automatic int lvl_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tensaurus_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// The head word is held in dout_reg so a word pushed into an empty FIFO is
// visible right after the push edge, while all storage stays in a plain
// array with registered reads.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   dout          current head word
//   full, empty   occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module tensaurus_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    rd_ptr_inc;

    assign full       = (count_reg == COUNT_FULL);
    assign empty      = (count_reg == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);
    assign dout       = dout_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            // Head register: take din when it becomes the head (empty FIFO, or
            // the only entry leaves while a new one arrives); otherwise take the
            // next stored word when the head is popped. The next slot cannot be
            // under write in that case because count > 1.
            if (do_push && (empty || (do_pop && count_reg == (AW+1)'(1)))) begin
                dout_reg <= din;
            end else if (do_pop && count_reg > (AW+1)'(1)) begin
                dout_reg <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/csf_coord_decoder.sv
// Compressed-sparse-fiber token decoder.
// Holds one index per fiber header level, expands each NNZ token into a full
// coordinate tuple {header indices, leaf index, value address} and buffers it
// in an output FIFO with valid/ready flow control. EOS stops input, waits for
// the FIFO to drain and then pulses done for one cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_levels               number of active header levels (1..NUM_LEVELS)
//   in_valid/in_ready        input token handshake
//   in_type/in_level/in_idx/in_addr  token fields
//   out_valid/out_ready      output tuple handshake
//   out_hdr_idx              header indices, level 0 in LSBs, inactive levels 0
//   out_leaf_idx, out_addr   leaf index and value address
//   done                     one-cycle pulse once an EOS has fully drained
//   err                      sticky protocol error
//   nnz_count                tuples buffered since the last done (saturating)
module csf_coord_decoder
    import tensaurus_pkg::*;
#(
    parameter int MEMORY_ADDRESS_SIZE = 10,
    parameter int INDEX_SIZE          = 8,
    parameter int NUM_LEVELS          = 2,
    parameter int FIFO_DEPTH          = 4,
    parameter int CNT_W               = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [lvl_width(NUM_LEVELS):0]   cfg_levels,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       in_type,
    input  logic [lvl_width(NUM_LEVELS)-1:0] in_level,
    input  logic [INDEX_SIZE-1:0]            in_idx,
    input  logic [MEMORY_ADDRESS_SIZE-1:0]   in_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LEVELS*INDEX_SIZE-1:0] out_hdr_idx,
    output logic [INDEX_SIZE-1:0]            out_leaf_idx,
    output logic [MEMORY_ADDRESS_SIZE-1:0]   out_addr,
    output logic                             done,
    output logic                             err,
    output logic [CNT_W-1:0]                 nnz_count
);

    localparam int LVL_W  = lvl_width(NUM_LEVELS);
    localparam int HDR_W  = NUM_LEVELS * INDEX_SIZE;
    localparam int WORD_W = HDR_W + INDEX_SIZE + MEMORY_ADDRESS_SIZE;
    localparam logic [LVL_W:0] NUM_LEVELS_L = (LVL_W+1)'(NUM_LEVELS);

    dec_state_t        state_reg;
    dec_state_t        state_next;
    logic              rdy_en_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  nnz_count_reg;

    tok_t              tok;
    logic              accept;
    logic [LVL_W:0]    level_ext;
    logic              hdr_level_ok;
    logic              hdr_wr;
    logic              nnz_ok;
    logic              nnz_push;
    logic              err_set;

    logic [NUM_LEVELS-1:0] lvl_ok;
    logic [HDR_W-1:0]      hdr_masked;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_din;
    logic [WORD_W-1:0] fifo_dout;

    assign tok          = tok_t'(in_type);
    assign accept       = in_valid && in_ready;
    assign level_ext    = {1'b0, in_level};
    assign hdr_level_ok = (level_ext < cfg_levels) && (level_ext < NUM_LEVELS_L);
    assign hdr_wr       = accept && (tok == TOK_HDR) && hdr_level_ok;
    assign nnz_ok       = &lvl_ok;
    assign nnz_push     = accept && (tok == TOK_NNZ) && nnz_ok;
    assign err_set      = accept && (((tok == TOK_HDR) && !hdr_level_ok) ||
                                     ((tok == TOK_NNZ) && !nnz_ok) ||
                                     (tok == TOK_RSVD));

    // Per-level header register. A new header at level L invalidates every
    // deeper level, since their indices belonged to the previous fiber.
    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_lvl
        localparam logic [LVL_W:0] LVL = (LVL_W+1)'(gi);
        logic [INDEX_SIZE-1:0] idx_reg;
        logic                  vld_reg;
        logic                  lvl_active;

        assign lvl_active = (LVL < cfg_levels);
        assign lvl_ok[gi] = !lvl_active || vld_reg;
        assign hdr_masked[gi*INDEX_SIZE +: INDEX_SIZE] = lvl_active ? idx_reg : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                idx_reg <= '0;
                vld_reg <= 1'b0;
            end else if (state_reg == ST_DONE) begin
                vld_reg <= 1'b0;
            end else if (hdr_wr) begin
                if (level_ext == LVL) begin
                    idx_reg <= in_idx;
                    vld_reg <= 1'b1;
                end else if (level_ext < LVL) begin
                    vld_reg <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            rdy_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rdy_en_reg <= 1'b1;
        end
    end

    // rdy_en_reg holds in_ready low until the first edge after reset release.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                in_ready = rdy_en_reg && !fifo_full;
                if (in_valid && rdy_en_reg && !fifo_full && (tok == TOK_EOS)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg       <= 1'b0;
            nnz_count_reg <= '0;
        end else begin
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (state_reg == ST_DONE) begin
                nnz_count_reg <= '0;
            end else if (nnz_push && (nnz_count_reg != '1)) begin
                nnz_count_reg <= nnz_count_reg + CNT_W'(1);
            end
        end
    end

    assign fifo_din = {hdr_masked, in_idx, in_addr};
    assign fifo_pop = out_valid && out_ready;

    tensaurus_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (nnz_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_hdr_idx  = fifo_dout[WORD_W-1 -: HDR_W];
    assign out_leaf_idx = fifo_dout[MEMORY_ADDRESS_SIZE +: INDEX_SIZE];
    assign out_addr     = fifo_dout[MEMORY_ADDRESS_SIZE-1:0];
    assign err          = err_reg;
    assign nnz_count    = nnz_count_reg;

endmodule

// File: tb/tb_csf_coord_decoder.sv
// Directed bench for csf_coord_decoder (default parameters).
module tb_csf_coord_decoder;
    import tensaurus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cfg_levels = 2'd2;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_type = 2'b00;
    logic [0:0]  in_level = 1'b0;
    logic [7:0]  in_idx = '0;
    logic [9:0]  in_addr = '0;
    logic        out_valid;
    wire         out_ready;
    logic [15:0] out_hdr_idx;
    logic [7:0]  out_leaf_idx;
    logic [9:0]  out_addr;
    logic        done;
    logic        err;
    logic [15:0] nnz_count;

    logic ready_en  = 1'b1;
    logic toggle_en = 1'b0;
    logic phase_reg = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) phase_reg <= ~phase_reg;
    assign out_ready = toggle_en ? phase_reg : ready_en;

    csf_coord_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_levels   (cfg_levels),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_type      (in_type),
        .in_level     (in_level),
        .in_idx       (in_idx),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hdr_idx  (out_hdr_idx),
        .out_leaf_idx (out_leaf_idx),
        .out_addr     (out_addr),
        .done         (done),
        .err          (err),
        .nnz_count    (nnz_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [33:0] tuple(input logic [15:0] hdr, input logic [7:0] leaf,
                                          input logic [9:0] addr);
        return {hdr, leaf, addr};
    endfunction

    // Output scoreboard: every popped tuple must match the next expected one.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_tuple", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("tuple", {30'd0, out_hdr_idx, out_leaf_idx, out_addr},
                         {30'd0, exp_q.pop_front()});
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [1:0] t, input logic lvl, input logic [7:0] idx,
                        input logic [9:0] addr);
        int   n   = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_type  = t;
        in_level = lvl;
        in_idx   = idx;
        in_addr  = addr;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent;
        int   done_cnt;
        logic chk_zero;
        logic acc;

        // Reset state
        idle(2);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_nnz_count", 64'(nnz_count), 64'd0);
        check_eq("rst_hdr", 64'(out_hdr_idx), 64'd0);
        rst = 1'b0;
        idle(1);
        check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);

        // 1: single tuple, visible right after the accept edge
        send(TOK_HDR, 1'b0, 8'd3, 10'h0);
        send(TOK_HDR, 1'b1, 8'd5, 10'h0);
        exp_q.push_back(tuple(16'h0503, 8'd7, 10'h012));
        send(TOK_NNZ, 1'b0, 8'd7, 10'h012);
        check_eq("t1_out_valid", 64'(out_valid), 64'd1);
        check_eq("t1_leaf", 64'(out_leaf_idx), 64'd7);
        check_eq("t1_nnz_count", 64'(nnz_count), 64'd1);
        idle(2);

        // 2: header update between NNZs, then missing deeper header
        send(TOK_HDR, 1'b0, 8'd1, 10'h0);
        send(TOK_HDR, 1'b1, 8'd2, 10'h0);
        exp_q.push_back(tuple(16'h0201, 8'd4, 10'h020));
        send(TOK_NNZ, 1'b0, 8'd4, 10'h020);
        send(TOK_HDR, 1'b1, 8'd9, 10'h0);
        exp_q.push_back(tuple(16'h0901, 8'd6, 10'h021));
        send(TOK_NNZ, 1'b0, 8'd6, 10'h021);
        check_eq("t2_err_before", 64'(err), 64'd0);
        send(TOK_HDR, 1'b0, 8'd8, 10'h0);
        send(TOK_NNZ, 1'b0, 8'd5, 10'h022);
        check_eq("t2_err", 64'(err), 64'd1);
        check_eq("t2_nnz_count", 64'(nnz_count), 64'd3);
        idle(3);
        check_eq("t2_dropped", 64'(out_valid), 64'd0);

        // 3: back-pressure fills the FIFO, then releases
        send(TOK_HDR, 1'b1, 8'd10, 10'h0);
        ready_en = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(tuple(16'h0A08, 8'(20 + i), 10'(10'h100 + i)));
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_type  = TOK_NNZ;
            in_level = 1'b0;
            in_idx   = 8'(20 + sent);
            in_addr  = 10'(10'h100 + sent);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check_eq("t3_accepts_when_full", 64'(sent), 64'd4);
        check_eq("t3_in_ready_full", 64'(in_ready), 64'd0);
        check_eq("t3_nnz_count", 64'(nnz_count), 64'd7);
        ready_en = 1'b1;
        send(TOK_NNZ, 1'b0, 8'd24, 10'h104);
        send(TOK_NNZ, 1'b0, 8'd25, 10'h105);
        idle(8);
        check_eq("t3_all_drained", 64'(exp_q.size()), 64'd0);
        check_eq("t3_nnz_count_end", 64'(nnz_count), 64'd9);

        // 4: EOS drain with toggling out_ready
        toggle_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(tuple(16'h0A08, 8'(30 + i), 10'(10'h040 + i)));
            send(TOK_NNZ, 1'b0, 8'(30 + i), 10'(10'h040 + i));
        end
        send(TOK_EOS, 1'b0, 8'd0, 10'h0);
        check_eq("t4_in_ready_drain", 64'(in_ready), 64'd0);
        done_cnt = 0;
        chk_zero = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (chk_zero) begin
                check_eq("t4_nnz_cleared", 64'(nnz_count), 64'd0);
                chk_zero = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check_eq("t4_drained_at_done", 64'(exp_q.size()), 64'd0);
                check_eq("t4_nnz_at_done", 64'(nnz_count), 64'd12);
                chk_zero = 1'b1;
            end else if (done_cnt == 0 && exp_q.size() != 0) begin
                check_eq("t4_in_ready_low", 64'(in_ready), 64'd0);
            end
            idle(1);
        end
        check_eq("t4_done_pulses", 64'(done_cnt), 64'd1);
        toggle_en = 1'b0;

        // 6: reset with buffered tuples discards everything
        ready_en = 1'b0;
        send(TOK_HDR, 1'b0, 8'd1, 10'h0);
        send(TOK_HDR, 1'b1, 8'd1, 10'h0);
        for (int i = 0; i < 3; i++) send(TOK_NNZ, 1'b0, 8'(40 + i), 10'(10'h050 + i));
        check_eq("t6_buffered", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_err", 64'(err), 64'd0);
        check_eq("t6_rst_nnz", 64'(nnz_count), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        ready_en = 1'b1;
        idle(2);
        check_eq("t6_fifo_empty", 64'(out_valid), 64'd0);
        send(TOK_NNZ, 1'b0, 8'd43, 10'h053);
        check_eq("t6_hdr_cleared_err", 64'(err), 64'd1);
        check_eq("t6_nnz_dropped", 64'(nnz_count), 64'd0);

        // 5: single header level
        do_reset();
        send(TOK_HDR, 1'b0, 8'd3, 10'h0);
        send(TOK_HDR, 1'b1, 8'd7, 10'h0);
        idle(1);
        cfg_levels = 2'd1;
        idle(1);
        send(TOK_HDR, 1'b1, 8'd5, 10'h0);
        check_eq("t5_hdr_level_err", 64'(err), 64'd1);
        send(TOK_HDR, 1'b0, 8'd4, 10'h0);
        exp_q.push_back(tuple(16'h0004, 8'd2, 10'h033));
        send(TOK_NNZ, 1'b0, 8'd2, 10'h033);
        check_eq("t5_hdr_masked", 64'(out_hdr_idx), 64'h0004);
        send(TOK_RSVD, 1'b0, 8'd9, 10'h0);
        check_eq("t5_rsvd_err", 64'(err), 64'd1);
        check_eq("t5_nnz_count", 64'(nnz_count), 64'd1);
        idle(3);
        check_eq("t5_rsvd_no_push", 64'(out_valid), 64'd0);
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
